// File: rtl/hmac_sha256_verifier.sv
// Drives a streaming HMAC-SHA256 hasher for one message and checks the resulting tag against an expected MAC.
// Latency: update 1 clk after the 4th/last byte, finalize 1 clk after the last update, done 1 clk after hash_valid.
// Backpressure: din_ready only in COLLECT/DRAIN; once the hasher is ready it is assumed never to stall.
module hmac_sha256_verifier #(
  parameter int unsigned MAX_MSG_BYTES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         verify_start,
  input  logic [511:0] key,
  input  logic [255:0] expected_mac,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [7:0]   din,
  input  logic         din_last,
  output logic [511:0] hmac_key,
  output logic         hmac_key_update,
  output logic         hmac_start,
  input  logic         hmac_ready,
  output logic         hmac_update,
  output logic [31:0]  hmac_data,
  output logic [2:0]   hmac_bytes_valid,
  output logic         hmac_finalize,
  input  logic         hmac_hash_valid,
  input  logic [255:0] hmac_hash,
  output logic         done,
  output logic         mac_ok,
  output logic         err_overflow,
  output logic         err_timeout,
  output logic [15:0]  msg_len
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_READY, S_COLLECT, S_FLUSH,
    S_FINAL, S_WAIT_HASH, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [511:0]    key_q, key_d;
  logic [255:0]    exp_q, exp_d;
  logic [31:0]     pack_q, pack_d;   // partially filled word, first byte in [31:24]
  logic [1:0]      lane_q, lane_d;   // number of bytes already held in pack_q
  logic [15:0]     len_q, len_d;
  logic            upd_q, upd_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      bv_q, bv_d;
  logic            ok_q, ok_d;
  logic            ovf_q, ovf_d;
  logic            to_q, to_d;
  logic [TW-1:0]   tmr_q, tmr_d;     // clocks elapsed since finalize

  logic [31:0]     packed_word;
  logic            at_limit;

  // A byte that arrives when MAX_MSG_BYTES are already counted would overflow.
  assign at_limit = ({1'b0, len_q} >= 17'(MAX_MSG_BYTES));

  // Merge the incoming byte into the next free lane, big-endian.
  always_comb begin
    packed_word = pack_q;
    case (lane_q)
      2'd0:    packed_word = {din, 24'h0};
      2'd1:    packed_word = {pack_q[31:24], din, 16'h0};
      2'd2:    packed_word = {pack_q[31:16], din, 8'h0};
      default: packed_word = {pack_q[31:8], din};
    endcase
  end

  // Next-state and strobe outputs for the verification sequence.
  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    exp_d           = exp_q;
    pack_d          = pack_q;
    lane_d          = lane_q;
    len_d           = len_q;
    upd_d           = 1'b0;
    data_d          = data_q;
    bv_d            = bv_q;
    ok_d            = ok_q;
    ovf_d           = ovf_q;
    to_d            = to_q;
    tmr_d           = tmr_q;
    din_ready       = 1'b0;
    hmac_start      = 1'b0;
    hmac_key_update = 1'b0;
    hmac_finalize   = 1'b0;
    done            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (verify_start) begin
          key_d   = key;
          exp_d   = expected_mac;
          ok_d    = 1'b0;
          ovf_d   = 1'b0;
          to_d    = 1'b0;
          len_d   = 16'h0;
          state_d = S_START;
        end
      end
      S_START: begin
        hmac_start      = 1'b1;
        hmac_key_update = 1'b1;
        pack_d          = 32'h0;
        lane_d          = 2'd0;
        state_d         = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (hmac_ready) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        din_ready = 1'b1;
        if (din_valid) begin
          if (at_limit) begin
            // Overflowing byte is swallowed; the hasher never sees it.
            ovf_d   = 1'b1;
            state_d = din_last ? S_DONE : S_DRAIN;
          end else begin
            len_d = len_q + 16'd1;
            if (lane_q == 2'd3 || din_last) begin
              upd_d  = 1'b1;
              data_d = packed_word;
              bv_d   = {1'b0, lane_q} + 3'd1;
              pack_d = 32'h0;
              lane_d = 2'd0;
            end else begin
              pack_d = packed_word;
              lane_d = lane_q + 2'd1;
            end
            if (din_last) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The final update registered on the last byte is on the bus now.
        state_d = S_FINAL;
      end
      S_FINAL: begin
        hmac_finalize = 1'b1;
        tmr_d         = TW'(1);
        state_d       = S_WAIT_HASH;
      end
      S_WAIT_HASH: begin
        if (hmac_hash_valid) begin
          ok_d    = (hmac_hash == exp_q);
          state_d = S_DONE;
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DRAIN: begin
        din_ready = 1'b1;
        if (din_valid && din_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any verification in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      exp_q   <= '0;
      pack_q  <= '0;
      lane_q  <= '0;
      len_q   <= '0;
      upd_q   <= 1'b0;
      data_q  <= '0;
      bv_q    <= '0;
      ok_q    <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      exp_q   <= exp_d;
      pack_q  <= pack_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      upd_q   <= upd_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      ok_q    <= ok_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      tmr_q   <= tmr_d;
    end
  end

  assign hmac_key         = key_q;
  assign hmac_update      = upd_q;
  assign hmac_data        = data_q;
  assign hmac_bytes_valid = bv_q;
  assign mac_ok           = ok_q;
  assign err_overflow     = ovf_q;
  assign err_timeout      = to_q;
  assign msg_len          = len_q;

endmodule

// File: tb/tb_hmac_sha256_verifier.sv
// Scoreboard bench for hmac_sha256_verifier with a behavioural HMAC-SHA256 hasher model.
// Latency: checks finalize-after-update gap and timeout distance in cycles.
// Backpressure: driver holds din_valid until din_ready is seen.
module tb_hmac_sha256_verifier;

  localparam int MAXB = 32;
  localparam int TMO  = 64;

  typedef logic [7:0] bq_t [$];
  typedef struct { logic [31:0] dat; logic [2:0] bv; } word_t;
  typedef struct { bit ok; bit ovf; bit to; bit chk_len; int len; } outc_t;

  localparam logic [31:0] SHA_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] SHA_H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         verify_start = 1'b0;
  logic [511:0] key = '0;
  logic [255:0] expected_mac = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [7:0]   din = '0;
  logic         din_last = 1'b0;
  logic [511:0] hmac_key;
  logic         hmac_key_update;
  logic         hmac_start;
  logic         hmac_ready;
  logic         hmac_update;
  logic [31:0]  hmac_data;
  logic [2:0]   hmac_bytes_valid;
  logic         hmac_finalize;
  logic         hmac_hash_valid;
  logic [255:0] hmac_hash;
  logic         done;
  logic         mac_ok;
  logic         err_overflow;
  logic         err_timeout;
  logic [15:0]  msg_len;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    no_respond = 1'b0;
  word_t word_q [$];
  outc_t out_q [$];

  hmac_sha256_verifier #(.MAX_MSG_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .verify_start(verify_start), .key(key),
    .expected_mac(expected_mac), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .din_last(din_last), .hmac_key(hmac_key),
    .hmac_key_update(hmac_key_update), .hmac_start(hmac_start),
    .hmac_ready(hmac_ready), .hmac_update(hmac_update), .hmac_data(hmac_data),
    .hmac_bytes_valid(hmac_bytes_valid), .hmac_finalize(hmac_finalize),
    .hmac_hash_valid(hmac_hash_valid), .hmac_hash(hmac_hash), .done(done),
    .mac_ok(mac_ok), .err_overflow(err_overflow), .err_timeout(err_timeout),
    .msg_len(msg_len));

  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input bq_t m);
    bq_t p;
    logic [31:0] h [0:7];
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [63:0] bl;
    p = m;
    bl = 64'(m.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    for (int i = 0; i < 8; i++) h[i] = SHA_H0[i];
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
               (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] hmac_model(input logic [511:0] k0, input bq_t msg);
    bq_t ib, ob;
    logic [255:0] ih;
    for (int i = 0; i < 64; i++) ib.push_back(k0[511-8*i -: 8] ^ 8'h36);
    foreach (msg[i]) ib.push_back(msg[i]);
    ih = sha256(ib);
    for (int i = 0; i < 64; i++) ob.push_back(k0[511-8*i -: 8] ^ 8'h5c);
    for (int i = 0; i < 32; i++) ob.push_back(ih[255-8*i -: 8]);
    return sha256(ob);
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Hasher model: gathers update bytes after start and answers finalize with the true HMAC.
  initial begin
    bq_t          hq;
    logic [511:0] hkey;
    int           rdy_cnt, hz_cnt;
    hkey = '0; rdy_cnt = 0; hz_cnt = 0;
    hmac_ready = 1'b0; hmac_hash_valid = 1'b0; hmac_hash = '0;
    forever begin
      @(posedge clk); #1;
      hmac_hash_valid = 1'b0;
      if (!rst_n) begin
        hq.delete(); hz_cnt = 0; hmac_ready = 1'b0;
      end else begin
        if (hmac_start) begin
          hkey = hmac_key; hq.delete(); hmac_ready = 1'b0; rdy_cnt = $urandom_range(1, 4);
        end else if (!hmac_ready) begin
          if (rdy_cnt <= 1) hmac_ready = 1'b1; else rdy_cnt--;
        end
        if (hmac_update)
          for (int i = 0; i < int'(hmac_bytes_valid); i++) hq.push_back(hmac_data[31-8*i -: 8]);
        if (hmac_finalize && !no_respond) begin
          hz_cnt = $urandom_range(1, 8);
        end else if (hz_cnt != 0) begin
          hz_cnt--;
          if (hz_cnt == 0) begin
            hmac_hash_valid = 1'b1;
            hmac_hash = hmac_model(hkey, hq);
          end
        end
      end
    end
  end

  // Monitor: compares every update and every done against the scoreboard queues.
  initial begin
    int    last_upd, fin_cyc;
    word_t w;
    outc_t o;
    last_upd = -100; fin_cyc = -100;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hmac_update) begin
          chk("update_expected", 64'(word_q.size() != 0), 64'd1);
          if (word_q.size() != 0) begin
            w = word_q.pop_front();
            chk("update_data", 64'(hmac_data), 64'(w.dat));
            chk("update_bytes_valid", 64'(hmac_bytes_valid), 64'(w.bv));
          end
          last_upd = cyc;
        end
        if (hmac_finalize) begin
          chk("finalize_gap", 64'(cyc - last_upd), 64'd1);
          if (out_q.size() != 0) chk("finalize_on_overflow", 64'(out_q[0].ovf), 64'd0);
          fin_cyc = cyc;
        end
        if (done) begin
          chk("done_expected", 64'(out_q.size() != 0), 64'd1);
          if (out_q.size() != 0) begin
            o = out_q.pop_front();
            chk("mac_ok", 64'(mac_ok), 64'(o.ok));
            chk("err_overflow", 64'(err_overflow), 64'(o.ovf));
            chk("err_timeout", 64'(err_timeout), 64'(o.to));
            if (o.chk_len) chk("msg_len", 64'(msg_len), 64'(o.len));
            if (o.to) chk("timeout_latency", 64'(cyc - fin_cyc), 64'(TMO));
            chk("updates_outstanding", 64'(word_q.size()), 64'd0);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [511:0] k, input logic [255:0] m);
    key = k; expected_mac = m; verify_start = 1'b1;
    @(posedge clk); #1;
    verify_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit noise);
    bit hs;
    int n;
    idle($urandom_range(0, 2));
    din = b; din_last = last; din_valid = 1'b1;
    verify_start = noise & ($urandom_range(0, 3) == 0);
    hs = 1'b0; n = 0;
    while (!hs && n < 200) begin
      @(negedge clk); hs = din_ready;
      @(posedge clk); #1; n++;
    end
    if (!hs) chk("din_handshake", 64'(hs), 64'd1);
    din_valid = 1'b0; din_last = 1'b0; verify_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_din_ready"}, 64'(din_ready), 64'd0);
    chk({tag, "_hmac_key"}, 64'(|hmac_key), 64'd0);
    chk({tag, "_start"}, 64'({hmac_start, hmac_key_update, hmac_update, hmac_finalize}), 64'd0);
    chk({tag, "_data_bv"}, 64'({hmac_data, hmac_bytes_valid}), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_status"}, 64'({mac_ok, err_overflow, err_timeout}), 64'd0);
    chk({tag, "_msg_len"}, 64'(msg_len), 64'd0);
  endtask

  // Reference model: derives the expected word stream and outcome from the byte list.
  task automatic run_msg(input logic [511:0] k, input logic [255:0] m, input bq_t msg,
                         input bit exp_ok, input bit noise);
    outc_t o;
    word_t w;
    int    n, cnt, waitc;
    o.ovf = (msg.size() > MAXB);
    o.to = no_respond && !o.ovf;
    o.ok = exp_ok && !o.ovf && !o.to;
    o.chk_len = !o.ovf;
    o.len = msg.size();
    n = o.ovf ? MAXB : msg.size();
    for (int i = 0; i < n; i += 4) begin
      cnt = (n - i < 4) ? n - i : 4;
      if (cnt == 4 || !o.ovf) begin
        w.dat = '0;
        for (int j = 0; j < cnt; j++) w.dat[31-8*j -: 8] = msg[i+j];
        w.bv = 3'(cnt);
        word_q.push_back(w);
      end
    end
    out_q.push_back(o);
    pulse_start(k, m);
    foreach (msg[i]) send_byte(msg[i], i == msg.size() - 1, noise);
    waitc = 0;
    while (out_q.size() != 0 && waitc < 2000) begin @(posedge clk); #1; waitc++; end
    if (out_q.size() != 0) begin
      chk("done_seen", 64'(out_q.size()), 64'd0);
      out_q.delete(); word_q.delete();
    end
    idle(2);
    @(negedge clk);
    chk("mac_ok_held", 64'(mac_ok), 64'(o.ok));
    chk("errors_held", 64'({err_overflow, err_timeout}), 64'({o.ovf, o.to}));
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t          msg;
    logic [511:0] k;
    logic [255:0] m, r;
    bit           ok;
    #(500000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t          msg;
    logic [511:0] k, k1;
    logic [255:0] m, mac1;
    bit           ok;
    int           len;

    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Known-answer vectors.
    k1 = {{20{8'h0b}}, 352'h0};
    mac1 = 256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;
    run_msg(k1, mac1, s2q("Hi There"), 1'b1, 1'b0);
    run_msg({"Jefe", 480'h0},
            256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843 ^ 256'd1,
            s2q("what do ya want for nothing?"), 1'b0, 1'b0);

    // Partial last word.
    k = {$urandom, $urandom, 448'h0};
    msg = s2q("Hi Th");
    run_msg(k, hmac_model(k, msg), msg, 1'b1, 1'b0);

    // Exactly at the length limit, then one byte over.
    msg.delete();
    for (int i = 0; i < MAXB; i++) msg.push_back(8'($urandom));
    run_msg(k, hmac_model(k, msg), msg, 1'b1, 1'b0);
    msg.push_back(8'($urandom));
    run_msg(k, hmac_model(k, msg), msg, 1'b1, 1'b0);

    // Hasher that never answers.
    no_respond = 1'b1;
    msg = s2q("timeout!x");
    run_msg(k, hmac_model(k, msg), msg, 1'b1, 1'b0);
    no_respond = 1'b0;

    // Reset in the middle of collection.
    msg = s2q("Hi There");
    pulse_start(k1, mac1);
    for (int i = 0; i < 3; i++) send_byte(msg[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    run_msg(k1, mac1, msg, 1'b1, 1'b0);

    // Randomised messages, tags and ignored verify_start pulses.
    for (int t = 0; t < 14; t++) begin
      k = '0;
      for (int i = 0; i < 16; i++) k[511-32*i -: 32] = (i < $urandom_range(1, 16)) ? $urandom : 32'h0;
      len = $urandom_range(1, MAXB + 4);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      m = hmac_model(k, msg);
      ok = ($urandom_range(0, 1) == 1);
      if (!ok) m = m ^ (256'd1 << $urandom_range(0, 255));
      run_msg(k, m, msg, ok, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
